// File: rtl/fifo_pkg.sv
// Shared helpers for the parametrised synchronous FIFO: derived widths and
// the pointer wrap-increment that also works for non-power-of-two depths.
package fifo_pkg;

    // Bits needed to hold an occupancy value in the range 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Bits needed to address depth entries; never less than one bit.
    function automatic int unsigned ptr_width(input int unsigned depth);
        int unsigned w;
        w = $clog2(depth);
        return (w < 1) ? 1 : w;
    endfunction

    // Advance a pointer by one and wrap from depth-1 back to zero. A plain
    // binary roll-over is only correct for power-of-two depths.
    function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr >= depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/fifo_sync_param_if.sv
// Producer/consumer bus of the synchronous FIFO. The FIFO uses the slave
// modport; whoever drives writes, reads and flushes uses the master modport.
interface fifo_sync_param_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
);
    logic             clear;
    logic [WIDTH-1:0] data_in;
    logic             wr_en;
    logic             rd_en;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             wr_ack;
    logic             overflow;
    logic             underflow;
    logic             full;
    logic             empty;
    logic             almostfull;
    logic             almostempty;
    logic [CNT_W-1:0] count;

    modport slave (
        input  clear, data_in, wr_en, rd_en,
        output data_out, data_valid, wr_ack, overflow, underflow,
               full, empty, almostfull, almostempty, count
    );

    modport master (
        output clear, data_in, wr_en, rd_en,
        input  data_out, data_valid, wr_ack, overflow, underflow,
               full, empty, almostfull, almostempty, count
    );
endinterface

// File: rtl/fifo_mem.sv
// Storage array of the FIFO: one synchronous write port, one asynchronous
// read port. Contents are deliberately not reset; validity is tracked by
// the pointers and count in the controlling logic.
module fifo_mem #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              i_wrEn,
    input  logic [ADDR_W-1:0] i_wrAddr,
    input  logic [WIDTH-1:0]  i_wrData,
    input  logic [ADDR_W-1:0] i_rdAddr,
    output logic [WIDTH-1:0]  o_rdData
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Store the incoming word at the write address on an accepted write.
    always_ff @(posedge clk) begin
        if (i_wrEn) begin
            r_mem[i_wrAddr] <= i_wrData;
        end
    end

    assign o_rdData = r_mem[i_rdAddr];

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with programmable almost-full/almost-empty
// thresholds, occupancy count, synchronous flush and an optional
// first-word-fall-through read mode.
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int FIFO_WIDTH      = 16,
    parameter int FIFO_DEPTH      = 8,
    parameter int ALMOST_FULL_TH  = FIFO_DEPTH - 1,
    parameter int ALMOST_EMPTY_TH = 1,
    parameter int FWFT            = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fifo_sync_param_if.slave     bus
);

    localparam int CNT_W = int'(cnt_width(FIFO_DEPTH));
    localparam int PTR_W = int'(ptr_width(FIFO_DEPTH));

    // Reject nonsensical configurations while elaborating.
    if (FIFO_WIDTH < 1) begin : g_errWidth
        $error("fifo_sync_param: FIFO_WIDTH must be >= 1");
    end
    if (FIFO_DEPTH < 2) begin : g_errDepth
        $error("fifo_sync_param: FIFO_DEPTH must be >= 2");
    end
    if (ALMOST_FULL_TH < 1 || ALMOST_FULL_TH > FIFO_DEPTH) begin : g_errAfTh
        $error("fifo_sync_param: ALMOST_FULL_TH must be in 1..FIFO_DEPTH");
    end
    if (ALMOST_EMPTY_TH < 0 || ALMOST_EMPTY_TH > FIFO_DEPTH - 1) begin : g_errAeTh
        $error("fifo_sync_param: ALMOST_EMPTY_TH must be in 0..FIFO_DEPTH-1");
    end
    if (FWFT != 0 && FWFT != 1) begin : g_errFwft
        $error("fifo_sync_param: FWFT must be 0 or 1");
    end

    logic [PTR_W-1:0]      r_wrPtr;
    logic [PTR_W-1:0]      r_rdPtr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_wrAck;
    logic                  r_overflow;
    logic                  r_underflow;

    logic [PTR_W-1:0]      w_wrPtrNext;
    logic [PTR_W-1:0]      w_rdPtrNext;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_rdAccept;
    logic                  w_wrAccept;
    logic [FIFO_WIDTH-1:0] w_rdData;
    logic [FIFO_WIDTH-1:0] w_dataOut;
    logic                  w_dataValid;

    // Status flags are pure decodes of the registered occupancy, so they
    // change one cycle after the edge that moved the count.
    assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_empty = (r_count == '0);

    // A flush overrides any read or write requested in the same cycle. A
    // write into a full FIFO still goes through when a read frees a slot on
    // the same edge; a read of an empty FIFO never bypasses a same-cycle write.
    assign w_rdAccept = bus.rd_en & ~w_empty & ~bus.clear;
    assign w_wrAccept = bus.wr_en & ~bus.clear & (~w_full | w_rdAccept);

    assign w_wrPtrNext = PTR_W'(wrap_inc(32'(r_wrPtr), FIFO_DEPTH));
    assign w_rdPtrNext = PTR_W'(wrap_inc(32'(r_rdPtr), FIFO_DEPTH));

    fifo_mem #(
        .WIDTH  (FIFO_WIDTH),
        .DEPTH  (FIFO_DEPTH),
        .ADDR_W (PTR_W)
    ) u_mem (
        .clk      (clk),
        .i_wrEn   (w_wrAccept),
        .i_wrAddr (r_wrPtr),
        .i_wrData (bus.data_in),
        .i_rdAddr (r_rdPtr),
        .o_rdData (w_rdData)
    );

    // Write pointer advances on each accepted write; flush rewinds it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
        end else if (bus.clear) begin
            r_wrPtr <= '0;
        end else if (w_wrAccept) begin
            r_wrPtr <= w_wrPtrNext;
        end
    end

    // Read pointer advances on each accepted read; flush rewinds it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdPtr <= '0;
        end else if (bus.clear) begin
            r_rdPtr <= '0;
        end else if (w_rdAccept) begin
            r_rdPtr <= w_rdPtrNext;
        end
    end

    // Occupancy moves only when exactly one of read/write is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (bus.clear) begin
            r_count <= '0;
        end else begin
            case ({w_wrAccept, w_rdAccept})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // One-cycle status pulses describing what happened to the previous
    // cycle's requests; a flush cycle reports nothing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrAck     <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (bus.clear) begin
            r_wrAck     <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_wrAck     <= w_wrAccept;
            r_overflow  <= bus.wr_en & w_full & ~w_rdAccept;
            r_underflow <= bus.rd_en & w_empty;
        end
    end

    if (FWFT == 0) begin : g_stdRead
        logic [FIFO_WIDTH-1:0] r_dataOut;
        logic                  r_dataValid;

        // Registered read: the popped word appears one edge after rd_en and
        // is held until the next accepted read.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_dataOut   <= '0;
                r_dataValid <= 1'b0;
            end else if (bus.clear) begin
                r_dataValid <= 1'b0;
            end else begin
                r_dataValid <= w_rdAccept;
                if (w_rdAccept) begin
                    r_dataOut <= w_rdData;
                end
            end
        end

        assign w_dataOut   = r_dataOut;
        assign w_dataValid = r_dataValid;
    end else begin : g_fwftRead
        // Head of the queue is always on display; rd_en just acknowledges it.
        assign w_dataOut   = w_rdData;
        assign w_dataValid = ~w_empty;
    end

    assign bus.data_out    = w_dataOut;
    assign bus.data_valid  = w_dataValid;
    assign bus.wr_ack      = r_wrAck;
    assign bus.overflow    = r_overflow;
    assign bus.underflow   = r_underflow;
    assign bus.full        = w_full;
    assign bus.empty       = w_empty;
    assign bus.almostfull  = (r_count >= CNT_W'(ALMOST_FULL_TH));
    assign bus.almostempty = (r_count <= CNT_W'(ALMOST_EMPTY_TH));
    assign bus.count       = r_count;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param: three instances cover the default
// standard-read configuration, a non-power-of-two depth with custom
// thresholds, and first-word-fall-through mode.
module tb_fifo_sync_param;

    logic clk;
    logic rst_n;
    int   compareCount;
    int   failCount;

    fifo_sync_param_if #(.WIDTH(16), .CNT_W(4)) busA ();
    fifo_sync_param_if #(.WIDTH(16), .CNT_W(3)) busB ();
    fifo_sync_param_if #(.WIDTH(16), .CNT_W(4)) busC ();

    fifo_sync_param u_dutA (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busA)
    );

    fifo_sync_param #(
        .FIFO_DEPTH      (6),
        .ALMOST_FULL_TH  (4),
        .ALMOST_EMPTY_TH (2)
    ) u_dutB (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busB)
    );

    fifo_sync_param #(
        .FWFT (1)
    ) u_dutC (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busC)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one bus for a cycle (the others idle), then step to just past
    // the next rising edge so outputs can be sampled.
    task automatic applyStimulus(input int sel, input logic wr, input logic rd,
                                 input logic clr, input logic [15:0] d);
        busA.wr_en = 1'b0; busA.rd_en = 1'b0; busA.clear = 1'b0; busA.data_in = '0;
        busB.wr_en = 1'b0; busB.rd_en = 1'b0; busB.clear = 1'b0; busB.data_in = '0;
        busC.wr_en = 1'b0; busC.rd_en = 1'b0; busC.clear = 1'b0; busC.data_in = '0;
        case (sel)
            0: begin busA.wr_en = wr; busA.rd_en = rd; busA.clear = clr; busA.data_in = d; end
            1: begin busB.wr_en = wr; busB.rd_en = rd; busB.clear = clr; busB.data_in = d; end
            default: begin busC.wr_en = wr; busC.rd_en = rd; busC.clear = clr; busC.data_in = d; end
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compareCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        compareCount = 0;
        failCount    = 0;
        rst_n        = 1'b0;
        busA.wr_en = 1'b0; busA.rd_en = 1'b0; busA.clear = 1'b0; busA.data_in = '0;
        busB.wr_en = 1'b0; busB.rd_en = 1'b0; busB.clear = 1'b0; busB.data_in = '0;
        busC.wr_en = 1'b0; busC.rd_en = 1'b0; busC.clear = 1'b0; busC.data_in = '0;
        #12;

        $display("[TB] reset state");
        checkOutput("rstA_empty", 32'(busA.empty), 32'd1);
        checkOutput("rstA_aempty", 32'(busA.almostempty), 32'd1);
        checkOutput("rstA_count", 32'(busA.count), 32'd0);
        checkOutput("rstA_full", 32'(busA.full), 32'd0);
        checkOutput("rstA_afull", 32'(busA.almostfull), 32'd0);
        checkOutput("rstA_dout", 32'(busA.data_out), 32'd0);
        checkOutput("rstA_dvalid", 32'(busA.data_valid), 32'd0);
        checkOutput("rstA_wrack", 32'(busA.wr_ack), 32'd0);
        checkOutput("rstC_dvalid", 32'(busC.data_valid), 32'd0);
        rst_n = 1'b1;

        $display("[TB] fill default FIFO");
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(0, 1'b1, 1'b0, 1'b0, 16'(i));
            checkOutput($sformatf("fill%0d_wrack", i), 32'(busA.wr_ack), 32'd1);
            checkOutput($sformatf("fill%0d_count", i), 32'(busA.count), 32'(i));
            checkOutput($sformatf("fill%0d_afull", i), 32'(busA.almostfull), 32'(i >= 7));
            checkOutput($sformatf("fill%0d_full", i), 32'(busA.full), 32'(i == 8));
        end
        applyStimulus(0, 1'b1, 1'b0, 1'b0, 16'hDEAD);
        checkOutput("ovf_overflow", 32'(busA.overflow), 32'd1);
        checkOutput("ovf_wrack", 32'(busA.wr_ack), 32'd0);
        checkOutput("ovf_count", 32'(busA.count), 32'd8);

        $display("[TB] drain default FIFO");
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(0, 1'b0, 1'b1, 1'b0, 16'h0);
            checkOutput($sformatf("drain%0d_dout", i), 32'(busA.data_out), 32'(i));
            checkOutput($sformatf("drain%0d_dvalid", i), 32'(busA.data_valid), 32'd1);
            checkOutput($sformatf("drain%0d_count", i), 32'(busA.count), 32'(8 - i));
        end
        for (int i = 9; i <= 10; i++) begin
            applyStimulus(0, 1'b0, 1'b1, 1'b0, 16'h0);
            checkOutput($sformatf("udf%0d_underflow", i), 32'(busA.underflow), 32'd1);
            checkOutput($sformatf("udf%0d_dvalid", i), 32'(busA.data_valid), 32'd0);
            checkOutput($sformatf("udf%0d_empty", i), 32'(busA.empty), 32'd1);
            checkOutput($sformatf("udf%0d_dout_hold", i), 32'(busA.data_out), 32'h8);
        end
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 16'h0);
        checkOutput("idle_underflow_pulse", 32'(busA.underflow), 32'd0);

        $display("[TB] simultaneous read/write at full and empty");
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(0, 1'b1, 1'b0, 1'b0, 16'h10 + 16'(i));
        end
        checkOutput("refill_full", 32'(busA.full), 32'd1);
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 16'hBEEF);
        checkOutput("fullrw_overflow", 32'(busA.overflow), 32'd0);
        checkOutput("fullrw_wrack", 32'(busA.wr_ack), 32'd1);
        checkOutput("fullrw_count", 32'(busA.count), 32'd8);
        checkOutput("fullrw_dout", 32'(busA.data_out), 32'h11);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(0, 1'b0, 1'b1, 1'b0, 16'h0);
            checkOutput($sformatf("beef%0d_dout", k), 32'(busA.data_out),
                        (k == 7) ? 32'hBEEF : 32'h12 + 32'(k));
            checkOutput($sformatf("beef%0d_count", k), 32'(busA.count), 32'(7 - k));
        end
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 16'h1234);
        checkOutput("emptyrw_underflow", 32'(busA.underflow), 32'd1);
        checkOutput("emptyrw_wrack", 32'(busA.wr_ack), 32'd1);
        checkOutput("emptyrw_count", 32'(busA.count), 32'd1);
        checkOutput("emptyrw_dvalid", 32'(busA.data_valid), 32'd0);
        applyStimulus(0, 1'b0, 1'b1, 1'b0, 16'h0);
        checkOutput("emptyrw_next_dout", 32'(busA.data_out), 32'h1234);
        checkOutput("emptyrw_next_dvalid", 32'(busA.data_valid), 32'd1);
        checkOutput("emptyrw_next_count", 32'(busA.count), 32'd0);

        $display("[TB] depth-6 wrap and thresholds");
        checkOutput("b_start_aempty", 32'(busB.almostempty), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1, 1'b1, 1'b0, 1'b0, 16'h100 + 16'(i));
            checkOutput($sformatf("bfill%0d_count", i), 32'(busB.count), 32'(i));
            checkOutput($sformatf("bfill%0d_afull", i), 32'(busB.almostfull), 32'(i >= 4));
            checkOutput($sformatf("bfill%0d_aempty", i), 32'(busB.almostempty), 32'(i <= 2));
        end
        for (int k = 0; k < 16; k++) begin
            applyStimulus(1, 1'b1, 1'b1, 1'b0, 16'h105 + 16'(k));
            checkOutput($sformatf("brw%0d_dout", k), 32'(busB.data_out), 32'h101 + 32'(k));
            checkOutput($sformatf("brw%0d_count", k), 32'(busB.count), 32'd4);
        end
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1, 1'b0, 1'b1, 1'b0, 16'h0);
            checkOutput($sformatf("bdrain%0d_dout", k), 32'(busB.data_out), 32'h111 + 32'(k));
            checkOutput($sformatf("bdrain%0d_afull", k), 32'(busB.almostfull), 32'd0);
            checkOutput($sformatf("bdrain%0d_aempty", k), 32'(busB.almostempty), 32'((3 - k) <= 2));
        end
        checkOutput("bdrain_empty", 32'(busB.empty), 32'd1);

        $display("[TB] first-word-fall-through");
        applyStimulus(2, 1'b1, 1'b0, 1'b0, 16'h00AA);
        checkOutput("fwft_dout", 32'(busC.data_out), 32'hAA);
        checkOutput("fwft_dvalid", 32'(busC.data_valid), 32'd1);
        applyStimulus(2, 1'b0, 1'b0, 1'b0, 16'h0);
        checkOutput("fwft_hold_dout", 32'(busC.data_out), 32'hAA);
        checkOutput("fwft_hold_count", 32'(busC.count), 32'd1);
        applyStimulus(2, 1'b0, 1'b1, 1'b0, 16'h0);
        checkOutput("fwft_pop_empty", 32'(busC.empty), 32'd1);
        checkOutput("fwft_pop_dvalid", 32'(busC.data_valid), 32'd0);
        applyStimulus(2, 1'b1, 1'b0, 1'b0, 16'h00B1);
        applyStimulus(2, 1'b1, 1'b0, 1'b0, 16'h00B2);
        checkOutput("fwft_head1", 32'(busC.data_out), 32'hB1);
        applyStimulus(2, 1'b0, 1'b1, 1'b0, 16'h0);
        checkOutput("fwft_head2", 32'(busC.data_out), 32'hB2);
        checkOutput("fwft_head2_count", 32'(busC.count), 32'd1);

        $display("[TB] flush and asynchronous reset");
        applyStimulus(0, 1'b1, 1'b0, 1'b0, 16'h21);
        applyStimulus(0, 1'b1, 1'b0, 1'b0, 16'h22);
        applyStimulus(0, 1'b1, 1'b0, 1'b0, 16'h23);
        checkOutput("preclr_count", 32'(busA.count), 32'd3);
        applyStimulus(0, 1'b1, 1'b1, 1'b1, 16'h99);
        checkOutput("clr_count", 32'(busA.count), 32'd0);
        checkOutput("clr_empty", 32'(busA.empty), 32'd1);
        checkOutput("clr_wrack", 32'(busA.wr_ack), 32'd0);
        checkOutput("clr_underflow", 32'(busA.underflow), 32'd0);
        checkOutput("clr_overflow", 32'(busA.overflow), 32'd0);
        checkOutput("clr_dvalid", 32'(busA.data_valid), 32'd0);
        checkOutput("clr_dout_hold", 32'(busA.data_out), 32'h1234);
        applyStimulus(0, 1'b1, 1'b0, 1'b0, 16'h55);
        checkOutput("burst_wrack", 32'(busA.wr_ack), 32'd1);
        checkOutput("burst_count", 32'(busA.count), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_count", 32'(busA.count), 32'd0);
        checkOutput("arst_empty", 32'(busA.empty), 32'd1);
        checkOutput("arst_aempty", 32'(busA.almostempty), 32'd1);
        checkOutput("arst_wrack", 32'(busA.wr_ack), 32'd0);
        checkOutput("arst_dout", 32'(busA.data_out), 32'd0);
        checkOutput("arst_dvalid", 32'(busA.data_valid), 32'd0);
        checkOutput("arst_full", 32'(busA.full), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
Parametrised single-clock synchronous FIFO; next generation of the team's 16x8 FIFO.
Adds programmable almost-full/almost-empty thresholds, an occupancy count output, and a synchronous flush.
Adds an optional first-word-fall-through (FWFT) read mode and a data_valid qualifier.
Sits between any producer/consumer pair in the same clock domain.

Parameters:
FIFO_WIDTH, 16, data word width in bits (>=1)
FIFO_DEPTH, 8, number of entries (>=2; any integer, power of two not required)
ALMOST_FULL_TH, FIFO_DEPTH-1, almostfull asserts when count >= this (1..FIFO_DEPTH)
ALMOST_EMPTY_TH, 1, almostempty asserts when count <= this (0..FIFO_DEPTH-1)
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
clear  input  1  synchronous flush
data_in  input  FIFO_WIDTH  write data
wr_en  input  1  write request
rd_en  input  1  read request (FWFT: pop acknowledge)
data_out  output  FIFO_WIDTH  read data
data_valid  output  1  data_out holds a valid popped/head word
wr_ack  output  1  previous-cycle write accepted
overflow  output  1  previous-cycle write rejected (full)
underflow  output  1  previous-cycle read rejected (empty)
full  output  1  count == FIFO_DEPTH
empty  output  1  count == 0
almostfull  output  1  count >= ALMOST_FULL_TH
almostempty  output  1  count <= ALMOST_EMPTY_TH
count  output  CNT_W  occupancy, CNT_W = $clog2(FIFO_DEPTH+1)

Behaviour:
- Reset (rst_n=0, async): wr_ptr=rd_ptr=count=0, data_out=0, data_valid=0, wr_ack=overflow=underflow=0, full=0, almostfull=0, empty=1, almostempty=1. Memory contents not reset.
- Write accepted: wr_en & (!full | rd_accept). Word stored at wr_ptr; wr_ptr increments and wraps FIFO_DEPTH-1 -> 0.
- Read accepted: rd_en & !empty. rd_ptr increments with the same wrap.
- count: +1 write only, -1 read only, unchanged for both or neither. Never exceeds FIFO_DEPTH; never underflows.
- Flags are combinational decodes of the registered count; they settle the cycle after the causing edge.
- wr_ack, overflow, underflow: registered, one-cycle pulses.
  - wr_ack = write accepted.
  - overflow = wr_en & full & !rd_accept.
  - underflow = rd_en & empty.
- Standard mode (FWFT=0):
  - Accepted read: data_out <= mem[rd_ptr] and data_valid <= 1 at the next edge (latency 1).
  - No read: data_valid <= 0 and data_out holds its value.
- FWFT mode (FWFT=1):
  - data_out = mem[rd_ptr] combinationally; data_valid = !empty.
  - rd_en pops the shown word; write-to-visible latency is 1 cycle.
- Simultaneous rd_en & wr_en:
  - Full: both accepted, count stays FIFO_DEPTH, no overflow.
  - Empty: write accepted; read rejected with underflow=1. The word is not bypassed; it becomes readable next cycle.
- clear=1: pointers and count reset to 0 at the edge and data_valid <= 0. clear has priority over rd_en/wr_en.
  - No wr_ack, overflow or underflow pulse is generated that cycle.
  - data_out holds (standard mode).
- Reset mid-operation: immediate return to reset values; in-flight pulses are dropped.
- Out-of-range parameters: elaboration-time $error.

Decomposition:
- Package fifo_pkg: function cnt_width(depth), and the wrap-increment function used for non-power-of-two pointers.
- One sub-module fifo_mem: FIFO_WIDTH x FIFO_DEPTH register array, one synchronous write port, one asynchronous read port, no reset.
- Pointer, count and flag control logic stays in fifo_sync_param.

Test Plan:
1. Reset, defaults, FWFT=0: after reset empty=1, almostempty=1, count=0. Write 0x0001..0x0008 -> wr_ack every cycle, count 8, full=1, almostfull=1 from count 7. Ninth write 0xDEAD -> overflow=1, count stays 8.
2. Drain test 1 -> data_out 0x0001..0x0008 in order, each one cycle after rd_en. Tenth read -> underflow=1, data_valid=0, empty=1.
3. Full + simultaneous rd/wr of 0xBEEF -> no overflow, count 8; 0xBEEF emerges 8 reads later. Empty + rd/wr 0x1234 -> underflow=1, count 1, next read returns 0x1234.
4. FIFO_DEPTH=6, ALMOST_FULL_TH=4, ALMOST_EMPTY_TH=2: 20 interleaved writes/reads -> pointer wraps 5->0 and data stays in order. almostfull toggles at count 4, almostempty at count 2.
5. FWFT=1: write 0x00AA while empty -> next cycle data_out=0x00AA, data_valid=1 without rd_en. rd_en pops it -> empty=1, data_valid=0.
6. Three words stored, clear=1 with wr_en=1 and rd_en=1 -> count 0, empty=1, no wr_ack or underflow. Assert rst_n=0 mid-burst -> all outputs at reset values asynchronously.
